// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, the ID/EX operand stage and the later pipeline stages.
// slave is the stage itself; master is whatever drives ID, EX/MEM and MEM/WB.
interface id_ex_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CTRLW = 5
);
    logic             id_valid;
    logic [RADDR-1:0] id_rs_addr;
    logic [RADDR-1:0] id_rt_addr;
    logic [XLEN-1:0]  id_rs_data;
    logic [XLEN-1:0]  id_rt_data;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [15:0]      id_imm;
    logic             id_ext_sign;
    logic [4:0]       id_shamt;
    logic [1:0]       id_lhs_sel;
    logic             id_alusrc;
    logic [CTRLW-1:0] id_ALUctr;
    logic             id_bgez, id_bgtz, id_blez, id_bltz, id_beq, id_bne, id_Branch;
    logic [RADDR-1:0] id_wb_addr;
    logic             id_reg_write, id_mem_read, id_mem_write;
    logic             exm_reg_write;
    logic [RADDR-1:0] exm_wb_addr;
    logic [XLEN-1:0]  exm_result;
    logic             wb_reg_write;
    logic [RADDR-1:0] wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             stall_in;
    logic             flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_lhs;
    logic [XLEN-1:0]  ex_rhs;
    logic [XLEN-1:0]  ex_store_data;
    logic [CTRLW-1:0] ex_ALUctr;
    logic             ex_bgez, ex_bgtz, ex_blez, ex_bltz, ex_beq, ex_bne, ex_Branch;
    logic [RADDR-1:0] ex_wb_addr;
    logic             ex_reg_write, ex_mem_read, ex_mem_write;
    logic             load_use_stall;

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_uses_rs, id_uses_rt, id_imm, id_ext_sign, id_shamt, id_lhs_sel,
               id_alusrc, id_ALUctr, id_bgez, id_bgtz, id_blez, id_bltz, id_beq,
               id_bne, id_Branch, id_wb_addr, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_wb_addr, exm_result, wb_reg_write, wb_addr, wb_data,
               stall_in, flush,
        output ex_valid, ex_lhs, ex_rhs, ex_store_data, ex_ALUctr, ex_bgez, ex_bgtz,
               ex_blez, ex_bltz, ex_beq, ex_bne, ex_Branch, ex_wb_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, load_use_stall
    );

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_uses_rs, id_uses_rt, id_imm, id_ext_sign, id_shamt, id_lhs_sel,
               id_alusrc, id_ALUctr, id_bgez, id_bgtz, id_blez, id_bltz, id_beq,
               id_bne, id_Branch, id_wb_addr, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_wb_addr, exm_result, wb_reg_write, wb_addr, wb_data,
               stall_in, flush,
        input  ex_valid, ex_lhs, ex_rhs, ex_store_data, ex_ALUctr, ex_bgez, ex_bgtz,
               ex_blez, ex_bltz, ex_beq, ex_bne, ex_Branch, ex_wb_addr, ex_reg_write,
               ex_mem_read, ex_mem_write, load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, forwards
// from EX/MEM and MEM/WB, bypasses WB at capture and raises load-use stalls.
module id_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CTRLW = 5
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);
    localparam int NBR = 7;

    logic             valid_reg;
    logic [RADDR-1:0] rs_addr_reg, rt_addr_reg, wb_addr_reg;
    logic [XLEN-1:0]  rs_reg, rt_reg, imm_ext_reg;
    logic [4:0]       shamt_reg;
    logic [1:0]       lhs_sel_reg;
    logic             alusrc_reg;
    logic [CTRLW-1:0] aluctr_reg;
    logic [NBR-1:0]   br_reg;
    logic             reg_write_reg, mem_read_reg, mem_write_reg;

    logic [XLEN-1:0]  fwd_rs, fwd_rt;
    logic [XLEN-1:0]  rs_next, rt_next, imm_ext_next;
    logic [NBR-1:0]   br_next, br_gated;
    logic             load_use;

    // EX/MEM wins over MEM/WB; register 0 never forwards.
    always_comb begin
        fwd_rs = rs_reg;
        if (bus.exm_reg_write && bus.exm_wb_addr != '0 && bus.exm_wb_addr == rs_addr_reg)
            fwd_rs = bus.exm_result;
        else if (bus.wb_reg_write && bus.wb_addr != '0 && bus.wb_addr == rs_addr_reg)
            fwd_rs = bus.wb_data;

        fwd_rt = rt_reg;
        if (bus.exm_reg_write && bus.exm_wb_addr != '0 && bus.exm_wb_addr == rt_addr_reg)
            fwd_rt = bus.exm_result;
        else if (bus.wb_reg_write && bus.wb_addr != '0 && bus.wb_addr == rt_addr_reg)
            fwd_rt = bus.wb_data;
    end

    // The register file does not write through, so WB is bypassed at capture.
    always_comb begin
        rs_next = bus.id_rs_data;
        if (bus.wb_reg_write && bus.wb_addr != '0 && bus.wb_addr == bus.id_rs_addr)
            rs_next = bus.wb_data;
        rt_next = bus.id_rt_data;
        if (bus.wb_reg_write && bus.wb_addr != '0 && bus.wb_addr == bus.id_rt_addr)
            rt_next = bus.wb_data;
        imm_ext_next = {{(XLEN-16){bus.id_ext_sign & bus.id_imm[15]}}, bus.id_imm};
    end

    assign br_next = {bus.id_bgez, bus.id_bgtz, bus.id_blez, bus.id_bltz,
                      bus.id_beq, bus.id_bne, bus.id_Branch};

    assign load_use = bus.id_valid && valid_reg && mem_read_reg && wb_addr_reg != '0 &&
                      ((bus.id_uses_rs && bus.id_rs_addr == wb_addr_reg) ||
                       (bus.id_uses_rt && bus.id_rt_addr == wb_addr_reg)) &&
                      !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            rs_addr_reg   <= '0;
            rt_addr_reg   <= '0;
            wb_addr_reg   <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            imm_ext_reg   <= '0;
            shamt_reg     <= '0;
            lhs_sel_reg   <= '0;
            alusrc_reg    <= 1'b0;
            aluctr_reg    <= '0;
            br_reg        <= '0;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else if (bus.stall_in) begin
            // Keep producers that are about to leave MEM/WB.
            rs_reg <= fwd_rs;
            rt_reg <= fwd_rt;
        end else if (bus.flush || load_use) begin
            valid_reg     <= 1'b0;
            aluctr_reg    <= '0;
            br_reg        <= '0;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            valid_reg     <= bus.id_valid;
            rs_addr_reg   <= bus.id_rs_addr;
            rt_addr_reg   <= bus.id_rt_addr;
            wb_addr_reg   <= bus.id_wb_addr;
            rs_reg        <= rs_next;
            rt_reg        <= rt_next;
            imm_ext_reg   <= imm_ext_next;
            shamt_reg     <= bus.id_shamt;
            lhs_sel_reg   <= bus.id_lhs_sel;
            alusrc_reg    <= bus.id_alusrc;
            aluctr_reg    <= bus.id_ALUctr;
            br_reg        <= br_next;
            reg_write_reg <= bus.id_reg_write;
            mem_read_reg  <= bus.id_mem_read;
            mem_write_reg <= bus.id_mem_write;
        end
    end

    generate
        for (genvar gi = 0; gi < NBR; gi++) begin : g_br_gate
            assign br_gated[gi] = br_reg[gi] & valid_reg;
        end
    endgenerate

    always_comb begin
        case (lhs_sel_reg)
            2'b01:   bus.ex_lhs = {{(XLEN-5){1'b0}}, shamt_reg};
            2'b10:   bus.ex_lhs = {{(XLEN-5){1'b0}}, fwd_rs[4:0]};
            default: bus.ex_lhs = fwd_rs;
        endcase
    end

    assign bus.ex_rhs         = alusrc_reg ? imm_ext_reg : fwd_rt;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_valid       = valid_reg;
    assign bus.ex_ALUctr      = aluctr_reg;
    assign bus.ex_wb_addr     = wb_addr_reg;
    assign bus.ex_reg_write   = reg_write_reg & valid_reg;
    assign bus.ex_mem_read    = mem_read_reg & valid_reg;
    assign bus.ex_mem_write   = mem_write_reg & valid_reg;
    assign bus.ex_bgez        = br_gated[6];
    assign bus.ex_bgtz        = br_gated[5];
    assign bus.ex_blez        = br_gated[4];
    assign bus.ex_bltz        = br_gated[3];
    assign bus.ex_beq         = br_gated[2];
    assign bus.ex_bne         = br_gated[1];
    assign bus.ex_Branch      = br_gated[0];
    assign bus.load_use_stall = load_use;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register for the Ex stage, placed directly upstream of the ALU. It latches decoded fields from ID and builds the ALU's lhs, rhs and 5-bit ALUctr, plus the branch flags. It resolves RAW hazards in two ways: forwarding from EX/MEM and MEM/WB, and a bypass from WB at the moment a field is captured. It detects load-use hazards and inserts bubbles when a flush, a load-use hazard or a downstream stall requires it.

Parameters:
XLEN, 32, datapath width
RADDR, 5, register address width
CTRLW, 5, ALUctr width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs_addr, id_rt_addr  in  RADDR  source register numbers
id_rs_data, id_rt_data  in  XLEN  register-file read data (the register file does not write through)
id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
id_imm  in  16  raw immediate
id_ext_sign  in  1  1 = sign-extend the immediate, 0 = zero-extend
id_shamt  in  5  shift amount field
id_lhs_sel  in  2  00 = rs, 01 = shamt, 10 = rs[4:0] (variable shift), 11 = rs
id_alusrc  in  1  1 = rhs is the extended immediate
id_ALUctr  in  CTRLW  ALU operation
id_bgez, id_bgtz, id_blez, id_bltz, id_beq, id_bne, id_Branch  in  1 each  branch flags
id_wb_addr  in  RADDR  destination register
id_reg_write, id_mem_read, id_mem_write  in  1 each  write-back / memory controls
exm_reg_write  in  1  EX/MEM stage writes a register
exm_wb_addr  in  RADDR  EX/MEM destination
exm_result  in  XLEN  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB stage writes a register
wb_addr  in  RADDR  MEM/WB destination
wb_data  in  XLEN  MEM/WB write data
stall_in  in  1  downstream stall: hold this stage
flush  in  1  ALU branch fail: discard the ID instruction
ex_valid  out  1  EX holds a real instruction
ex_lhs, ex_rhs  out  XLEN  ALU operands
ex_store_data  out  XLEN  forwarded rt value
ex_ALUctr  out  CTRLW  registered ALU operation
ex_bgez, ex_bgtz, ex_blez, ex_bltz, ex_beq, ex_bne, ex_Branch  out  1 each  registered branch flags, gated by ex_valid
ex_wb_addr  out  RADDR  registered destination
ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls, gated by ex_valid
load_use_stall  out  1  ID and IF must hold this cycle

Behaviour:
- Update priority at the rising edge: rst > stall_in > flush > load_use_stall > capture.
- rst: every register goes to 0, so ex_valid = 0, all controls and flags = 0, ALUctr = 0 and operands = 0.
- stall_in (hold):
  - All fields are held.
  - rs_q and rt_q are re-latched with their currently forwarded values, so that producers leaving MEM/WB are not lost.
  - flush is ignored while stall_in = 1. The failing branch remains in EX, so fail stays asserted and flush is taken once the stall releases.
- flush, or load_use_stall: a bubble is loaded (valid = 0, all controls and flags = 0).
- Capture: every ID field is registered with a latency of 1 cycle.
  - rs/rt data is bypassed from WB when wb_reg_write & wb_addr != 0 & wb_addr == the source address.
  - The immediate is extended to XLEN at capture.
- Forwarding, combinational in EX, applied to rs_q and rt_q:
  - The EX/MEM source is used if exm_reg_write & exm_wb_addr != 0 & the address matches.
  - Otherwise the MEM/WB source is used under the same rule.
  - Otherwise the registered value is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand selection:
  - ex_lhs by lhs_sel: 00 or 11 → fwd_rs; 01 → {27'b0, shamt_q}; 10 → {27'b0, fwd_rs[4:0]}.
  - ex_rhs = alusrc_q ? imm_ext_q : fwd_rt.
  - ex_store_data = fwd_rt.
- load_use_stall = id_valid & ex_valid & ex_mem_read & ex_wb_addr != 0 & ((id_uses_rs & id_rs_addr == ex_wb_addr) | (id_uses_rt & id_rt_addr == ex_wb_addr)) & ~flush.
  - The bubble lets the load reach MEM/WB, where the consumer then forwards from it.
- ex_valid = 0 forces every control, branch flag and write-enable output to 0. Operands are don't-care in that case.

Test Plan:
- Back-to-back dependency: addu $3 = 5 followed by addu $4 = $3 + $3 → in the consumer's EX cycle, with exm_result = 5, ex_lhs = ex_rhs = 5.
- Priority and $0: exm and wb both target $3 with exm_result = 7 and wb_data = 9 → ex_lhs = 7. A producer targeting $0 with value 9 is not forwarded; the register-file value 0 is used.
- Load-use: lw $5 followed by addu using $5 → load_use_stall = 1 for exactly 1 cycle and a bubble (ex_valid = 0) is inserted. Next cycle, wb_data = 0x1234 is forwarded and ex_lhs = 0x1234.
- Flush: flush = 1 with id_valid = 1 and id_reg_write = 1 → next cycle ex_valid = 0, ex_reg_write = 0, ex_Branch = 0. load_use_stall is suppressed.
- stall_in held 3 cycles while a producer of $2 = 0x55 drains past WB → ex_lhs stays 0x55 throughout and after release. A flush asserted during the stall takes effect on the first non-stalled edge.
- Immediate and variable shift: id_imm = 16'h8000 with id_ext_sign = 1 → rhs = 0xFFFF8000, and with id_ext_sign = 0 → 0x00008000. lhs_sel = 10 with rs = 0x23 → ex_lhs = 3. rst mid-stream → all outputs 0 on the next edge.
